bp_me_burst_sink_arbiter: RTL and testbench

// - Locking round-robin arbiter/sequencer for one BedRock Burst sink shared by N sources.
// - Grants one source per message and holds the grant from header through the last data beat.
// - Emits a one-hot grant that drives an external header/data mux (bsg_crossbar_o_by_i column).
// - Sits per-sink in the ME burst network ahead of the sink's input buffer.

---
 rtl/bp_me_burst_sink_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bp_me_burst_sink_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bp_me_burst_sink_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_me_burst_sink_arbiter                                     |
// | Description : Locking round-robin arbiter for one BedRock burst sink that  |
// |               is shared by num_source_p sources. A source wins on its      |
// |               header and keeps the grant until its last data beat.         |
// |               Optional feature macro: BP_ME_BURST_ARB_HOLD_LIMIT_EN        |
// |               (sticky hold_timeout_o after 255 stalled locked cycles).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_me_burst_sink_arbiter #(
  parameter int num_source_p = 4,
  localparam int lg_num_source_lp = (num_source_p > 1) ? $clog2(num_source_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [num_source_p-1:0]     src_header_v_i,
  input  logic [num_source_p-1:0]     src_has_data_i,
  output logic [num_source_p-1:0]     src_header_yumi_o,
  input  logic [num_source_p-1:0]     src_data_v_i,
  input  logic [num_source_p-1:0]     src_last_i,
  output logic [num_source_p-1:0]     src_data_yumi_o,
  output logic                        sink_header_v_o,
  input  logic                        sink_header_ready_and_i,
  output logic                        sink_data_v_o,
  input  logic                        sink_data_ready_and_i,
  output logic [num_source_p-1:0]     grant_one_hot_o,
  output logic [lg_num_source_lp-1:0] grant_id_o,
  output logic                        busy_o,
  output logic                        hold_timeout_o
);

  typedef enum logic [0:0] {
    e_ready = 1'b0,
    e_data  = 1'b1
  } state_e;

  state_e                       state, state_nxt;
  logic [lg_num_source_lp-1:0]  rr_ptr, rr_nxt;
  logic [lg_num_source_lp-1:0]  lock_id, lock_nxt;

  logic                         found;
  logic [lg_num_source_lp-1:0]  search_id;
  logic [lg_num_source_lp:0]    cand_sum;

  logic [num_source_p-1:0]      hdr_yumi, dat_yumi, grant_oh;
  logic [lg_num_source_lp-1:0]  grant_id;
  logic                         hdr_v, dat_v;

  // Advance a source index by one, wrapping N-1 back to 0.
  function automatic logic [lg_num_source_lp-1:0] wrap_inc(input logic [lg_num_source_lp-1:0] v);
    if (v == lg_num_source_lp'(num_source_p - 1)) return '0;
    else return v + 1'b1;
  endfunction

  // Round-robin search: first valid header at or above the pointer, wrapping.
  always_comb begin
    found     = 1'b0;
    search_id = '0;
    cand_sum  = '0;
    for (int i = 0; i < num_source_p; i++) begin
      cand_sum = {1'b0, rr_ptr} + (lg_num_source_lp+1)'(i);
      if (cand_sum >= (lg_num_source_lp+1)'(num_source_p))
        cand_sum = cand_sum - (lg_num_source_lp+1)'(num_source_p);
      if (!found && src_header_v_i[cand_sum[lg_num_source_lp-1:0]]) begin
        found     = 1'b1;
        search_id = cand_sum[lg_num_source_lp-1:0];
      end
    end
  end

  // Next-state, pointer/lock update and handshake outputs.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    lock_nxt  = lock_id;
    grant_id  = '0;
    grant_oh  = '0;
    hdr_v     = 1'b0;
    dat_v     = 1'b0;
    hdr_yumi  = '0;
    dat_yumi  = '0;
    case (state)
      e_ready: begin
        hdr_v = |src_header_v_i;
        if (found) begin
          grant_id           = search_id;
          grant_oh[search_id] = 1'b1;
        end
        if (hdr_v && sink_header_ready_and_i) begin
          hdr_yumi[search_id] = 1'b1;
          if (src_has_data_i[search_id]) begin
            // Pointer holds until the burst completes so the grant is stable.
            lock_nxt  = search_id;
            state_nxt = e_data;
          end else begin
            rr_nxt = wrap_inc(search_id);
          end
        end
      end
      e_data: begin
        grant_id          = lock_id;
        grant_oh[lock_id] = 1'b1;
        dat_v             = src_data_v_i[lock_id];
        if (dat_v && sink_data_ready_and_i) begin
          dat_yumi[lock_id] = 1'b1;
          if (src_last_i[lock_id]) begin
            state_nxt = e_ready;
            rr_nxt    = wrap_inc(lock_id);
          end
        end
      end
      default: state_nxt = e_ready;
    endcase
  end

  // State, round-robin pointer and lock register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= e_ready;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_nxt;
      lock_id <= lock_nxt;
    end
  end

  // Outputs forced low while reset is held, independent of the clock.
  assign src_header_yumi_o = reset_n_i ? hdr_yumi : '0;
  assign src_data_yumi_o   = reset_n_i ? dat_yumi : '0;
  assign sink_header_v_o   = reset_n_i & hdr_v;
  assign sink_data_v_o     = reset_n_i & dat_v;
  assign grant_one_hot_o   = reset_n_i ? grant_oh : '0;
  assign grant_id_o        = reset_n_i ? grant_id : '0;
  assign busy_o            = reset_n_i & (state == e_data);

`ifdef BP_ME_BURST_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  logic       hold_to;

  // Count stalled cycles of the current lock; flag sticks once 255 is reached.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_cnt <= '0;
      hold_to  <= 1'b0;
    end else begin
      if (state == e_ready)
        hold_cnt <= '0;
      else if (!dat_v && hold_cnt != 8'd255)
        hold_cnt <= hold_cnt + 8'd1;
      if (state == e_data && !dat_v && hold_cnt == 8'd254)
        hold_to <= 1'b1;
    end
  end

  assign hold_timeout_o = hold_to;
`else
  assign hold_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_burst_sink_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_me_burst_sink_arbiter                                  |
// | Description : Directed bench for bp_me_burst_sink_arbiter. Stimulus pushes |
// |               expected handshakes ({is_data, src}) into a queue; a monitor |
// |               pops one entry per observed yumi and compares.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bp_me_burst_sink_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] hv, hd, hy, dv, dl, dy, goh;
  logic         shv, shr, sdv, sdr, busy, hto;
  logic [1:0]   gid;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0]   exp_q[$];
  logic [2:0]   obs, expv;
  logic [N-1:0] ymon, oh_exp;
  logic [N-1:0] one4;

  always #5 clk = ~clk;

  bp_me_burst_sink_arbiter #(.num_source_p(N)) dut (
    .clk_i                  (clk),
    .reset_n_i              (rst_n),
    .src_header_v_i         (hv),
    .src_has_data_i         (hd),
    .src_header_yumi_o      (hy),
    .src_data_v_i           (dv),
    .src_last_i             (dl),
    .src_data_yumi_o        (dy),
    .sink_header_v_o        (shv),
    .sink_header_ready_and_i(shr),
    .sink_data_v_o          (sdv),
    .sink_data_ready_and_i  (sdr),
    .grant_one_hot_o        (goh),
    .grant_id_o             (gid),
    .busy_o                 (busy),
    .hold_timeout_o         (hto)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected handshake: is_data=1 for a data beat, 0 for a header
  task automatic expect_hs(input logic is_data, input int src);
    exp_q.push_back({is_data, 2'(src)});
  endtask

  // Monitor: every observed dequeue must match the next expected handshake.
  always @(negedge clk) begin
    ymon = hy | dy;
    if (ymon != '0) begin
      obs = {|dy, 2'b00};
      for (int i = 0; i < N; i++) if (ymon[i]) obs[1:0] = 2'(i);
      check("yumi_onehot", $countones(ymon), 1);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_handshake: got %0h required none at %0t", obs, $time);
      end else begin
        expv = exp_q.pop_front();
        one4 = 4'b0001;
        oh_exp = one4 << expv[1:0];
        check("handshake", {29'd0, obs}, {29'd0, expv});
        check("grant_id", {30'd0, gid}, {30'd0, expv[1:0]});
        check("grant_one_hot", {28'd0, goh}, {28'd0, oh_exp});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    hv = 4'b1111; hd = '0; dv = '0; dl = '0;
    shr = 1'b1; sdr = 1'b1;

    // Reset: outputs held at zero even with headers pending.
    #12;
    check("reset_header_v", {31'd0, shv}, 0);
    check("reset_header_yumi", {28'd0, hy}, 0);
    check("reset_grant", {28'd0, goh}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_hold_timeout", {31'd0, hto}, 0);
    hv = '0;
    step();
    rst_n = 1'b1;
    step();

    // All four header-only every cycle: 0,1,2,3,0 (pointer ends at 1).
    hv = 4'b1111; hd = '0;
    expect_hs(0, 0); expect_hs(0, 1); expect_hs(0, 2); expect_hs(0, 3); expect_hs(0, 0);
    repeat (5) step();
    hv = '0;
    step();

    // src1 header with 4-beat burst; src2 header-only waiting throughout.
    hv = 4'b0110; hd = 4'b0010;
    expect_hs(0, 1);
    step();
    check("busy_locked", {31'd0, busy}, 1);
    hv = 4'b0100; hd = '0;
    dv = 4'b0010;
    expect_hs(1, 1);
    step();
    // Sink stalls data for 10 cycles: grant frozen on src1, no dequeue.
    sdr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("stall_grant", {28'd0, goh}, 32'h2);
      check("stall_yumi", {24'd0, hy, dy}, 0);
      step();
    end
    sdr = 1'b1;
    expect_hs(1, 1); expect_hs(1, 1);
    repeat (2) step();
    dl = 4'b0010;
    expect_hs(1, 1);
    step();
    dv = '0; dl = '0;
    expect_hs(0, 2);
    step();
    hv = '0;
    step();

    // Lock on src3 (pointer 3); after last beat search wraps to src0.
    hv = 4'b1000; hd = 4'b1000;
    expect_hs(0, 3);
    step();
    hv = 4'b0101; hd = '0;
    dv = 4'b1000;
    expect_hs(1, 3);
    step();
    dl = 4'b1000;
    expect_hs(1, 3);
    step();
    dv = '0; dl = '0;
    expect_hs(0, 0);
    step();
    hv = 4'b0100;
    expect_hs(0, 2);
    step();
    hv = '0;
    step();

    // Reset mid-burst (after beat 2 of 4); next grant is src0.
    hv = 4'b0010; hd = 4'b0010;
    expect_hs(0, 1);
    step();
    hv = '0; hd = '0;
    dv = 4'b0010;
    expect_hs(1, 1); expect_hs(1, 1);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_data_v", {31'd0, sdv}, 0);
    check("midreset_data_yumi", {28'd0, dy}, 0);
    check("midreset_grant", {28'd0, goh}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    dv = '0;
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_busy", {31'd0, busy}, 0);
    hv = 4'b1111;
    expect_hs(0, 0);
    step();
    hv = '0;

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    check("final_busy", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
